// File: rtl/dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_port_arbiter
// Description : Shares one data memory between two cores with independent
//               write and read arbitration channels. Defining
//               DM_ARB_FIXED_PRIORITY_EN makes core 0 win every tie.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DW         = 64,
    parameter int TW         = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    // write requesters
    input  logic [1:0]              wr_req,
    input  logic [2*ADDR_WIDTH-1:0] wr_addr,
    input  logic [2*DW-1:0]         wr_data,
    input  logic [2*TW-1:0]         wr_type,
    output logic [1:0]              wr_ack,
    // read requesters
    input  logic [1:0]              rd_req,
    input  logic [2*ADDR_WIDTH-1:0] rd_addr,
    input  logic [2*TW-1:0]         rd_type,
    output logic [DW-1:0]           rd_data,
    output logic [1:0]              rd_ack,
    // memory write channel
    output logic [DW-1:0]           data_bus_wr,
    output logic [ADDR_WIDTH-1:0]   addr_wr,
    output logic [TW-1:0]           data_type_wr,
    output logic                    wr_ins,
    input  logic                    wr_idle,
    // memory read channel
    input  logic [DW-1:0]           data_bus_rd,
    output logic [ADDR_WIDTH-1:0]   addr_rd,
    output logic [TW-1:0]           data_type_rd,
    output logic                    rd_ins,
    input  logic                    rd_idle
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Write channel signals
    // ------------------------------------------------------------------
    state_t                  r_wr_state;
    state_t                  w_wr_state_nxt;
    logic                    r_wr_grant;
    logic                    w_wr_grant;
    logic                    w_wr_start;
    logic                    w_wr_ins;
    logic [1:0]              w_wr_ack;
    logic [DW-1:0]           r_data_bus_wr;
    logic [ADDR_WIDTH-1:0]   r_addr_wr;
    logic [TW-1:0]           r_data_type_wr;
    logic [DW-1:0]           w_wr_data_sel;
    logic [ADDR_WIDTH-1:0]   w_wr_addr_sel;
    logic [TW-1:0]           w_wr_type_sel;

    // ------------------------------------------------------------------
    // Read channel signals
    // ------------------------------------------------------------------
    state_t                  r_rd_state;
    state_t                  w_rd_state_nxt;
    logic                    r_rd_grant;
    logic                    w_rd_grant;
    logic                    w_rd_start;
    logic                    w_rd_ins;
    logic [1:0]              w_rd_ack;
    logic [DW-1:0]           r_rd_data;
    logic [ADDR_WIDTH-1:0]   r_addr_rd;
    logic [TW-1:0]           r_data_type_rd;
    logic [ADDR_WIDTH-1:0]   w_rd_addr_sel;
    logic [TW-1:0]           w_rd_type_sel;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
`ifdef DM_ARB_FIXED_PRIORITY_EN
    // Core 0 wins any tie; core 1 is served only when core 0 is quiet.
    assign w_wr_grant = ~wr_req[0];
    assign w_rd_grant = ~rd_req[0];
`else
    logic r_wr_last;
    logic r_rd_last;

    // Round-robin pointer: the core served last loses the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_last <= 1'b1;
            r_rd_last <= 1'b1;
        end else begin
            if (r_wr_state == ST_ACK) begin
                r_wr_last <= r_wr_grant;
            end
            if (r_rd_state == ST_ACK) begin
                r_rd_last <= r_rd_grant;
            end
        end
    end

    assign w_wr_grant = (&wr_req) ? ~r_wr_last : wr_req[1];
    assign w_rd_grant = (&rd_req) ? ~r_rd_last : rd_req[1];
`endif

    assign w_wr_data_sel = w_wr_grant ? wr_data[2*DW-1:DW]                 : wr_data[DW-1:0];
    assign w_wr_addr_sel = w_wr_grant ? wr_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : wr_addr[ADDR_WIDTH-1:0];
    assign w_wr_type_sel = w_wr_grant ? wr_type[2*TW-1:TW]                 : wr_type[TW-1:0];
    assign w_rd_addr_sel = w_rd_grant ? rd_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : rd_addr[ADDR_WIDTH-1:0];
    assign w_rd_type_sel = w_rd_grant ? rd_type[2*TW-1:TW]                 : rd_type[TW-1:0];

    assign w_wr_start = (r_wr_state == ST_IDLE) && (|wr_req) && wr_idle;
    assign w_rd_start = (r_rd_state == ST_IDLE) && (|rd_req) && rd_idle;

    // ------------------------------------------------------------------
    // Write sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state     <= ST_IDLE;
            r_wr_grant     <= 1'b0;
            r_data_bus_wr  <= '0;
            r_addr_wr      <= '0;
            r_data_type_wr <= '0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            if (w_wr_start) begin
                r_wr_grant     <= w_wr_grant;
                r_data_bus_wr  <= w_wr_data_sel;
                r_addr_wr      <= w_wr_addr_sel;
                r_data_type_wr <= w_wr_type_sel;
            end
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_ins       = 1'b0;
        w_wr_ack       = 2'b00;
        case (r_wr_state)
            ST_IDLE: begin
                if (w_wr_start) begin
                    w_wr_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_wr_ins       = 1'b1;
                w_wr_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wr_idle) begin
                    w_wr_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_wr_ack[r_wr_grant] = 1'b1;
                w_wr_state_nxt       = ST_IDLE;
            end
            default: begin
                w_wr_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state     <= ST_IDLE;
            r_rd_grant     <= 1'b0;
            r_addr_rd      <= '0;
            r_data_type_rd <= '0;
            r_rd_data      <= '0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (w_rd_start) begin
                r_rd_grant     <= w_rd_grant;
                r_addr_rd      <= w_rd_addr_sel;
                r_data_type_rd <= w_rd_type_sel;
            end
            // Memory result is stable once the read channel reports idle.
            if ((r_rd_state == ST_WAIT) && rd_idle) begin
                r_rd_data <= data_bus_rd;
            end
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_ins       = 1'b0;
        w_rd_ack       = 2'b00;
        case (r_rd_state)
            ST_IDLE: begin
                if (w_rd_start) begin
                    w_rd_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_rd_ins       = 1'b1;
                w_rd_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (rd_idle) begin
                    w_rd_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_rd_ack[r_rd_grant] = 1'b1;
                w_rd_state_nxt       = ST_IDLE;
            end
            default: begin
                w_rd_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_ins       = w_wr_ins;
    assign wr_ack       = w_wr_ack;
    assign data_bus_wr  = r_data_bus_wr;
    assign addr_wr      = r_addr_wr;
    assign data_type_wr = r_data_type_wr;

    assign rd_ins       = w_rd_ins;
    assign rd_ack       = w_rd_ack;
    assign rd_data      = r_rd_data;
    assign addr_rd      = r_addr_rd;
    assign data_type_rd = r_data_type_rd;

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_port_arbiter
// Description : Directed bench for dm_port_arbiter with a small latency-
//               programmable memory model behind both channels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 64;
    localparam int TW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      wr_req;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic [2*TW-1:0] wr_type;
    logic [1:0]      wr_ack;
    logic [1:0]      rd_req;
    logic [2*AW-1:0] rd_addr;
    logic [2*TW-1:0] rd_type;
    logic [DW-1:0]   rd_data;
    logic [1:0]      rd_ack;
    logic [DW-1:0]   data_bus_wr;
    logic [AW-1:0]   addr_wr;
    logic [TW-1:0]   data_type_wr;
    logic            wr_ins;
    logic            wr_idle;
    logic [DW-1:0]   data_bus_rd;
    logic [AW-1:0]   addr_rd;
    logic [TW-1:0]   data_type_rd;
    logic            rd_ins;
    logic            rd_idle;

    dm_port_arbiter #(.ADDR_WIDTH(AW), .DW(DW), .TW(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_type      (wr_type),
        .wr_ack       (wr_ack),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_type      (rd_type),
        .rd_data      (rd_data),
        .rd_ack       (rd_ack),
        .data_bus_wr  (data_bus_wr),
        .addr_wr      (addr_wr),
        .data_type_wr (data_type_wr),
        .wr_ins       (wr_ins),
        .wr_idle      (wr_idle),
        .data_bus_rd  (data_bus_rd),
        .addr_rd      (addr_rd),
        .data_type_rd (data_type_rd),
        .rd_ins       (rd_ins),
        .rd_idle      (rd_idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: idle drops after an accepted ins and stays low *_lat cycles.
    logic          mem_wr_idle, mem_rd_idle;
    logic          wr_block, rd_block;
    int            wr_cnt, rd_cnt;
    int            wr_lat, rd_lat;
    logic [AW-1:0] rd_lat_addr;

    assign wr_idle     = mem_wr_idle & ~wr_block;
    assign rd_idle     = mem_rd_idle & ~rd_block;
    assign data_bus_rd = {8{rd_lat_addr}};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wr_idle <= 1'b1;
            mem_rd_idle <= 1'b1;
            wr_cnt      <= 0;
            rd_cnt      <= 0;
            rd_lat_addr <= '0;
        end else begin
            if (wr_ins && wr_idle) begin
                mem_wr_idle <= 1'b0;
                wr_cnt      <= wr_lat;
            end else if (!mem_wr_idle) begin
                if (wr_cnt <= 1) mem_wr_idle <= 1'b1;
                else             wr_cnt <= wr_cnt - 1;
            end
            if (rd_ins && rd_idle) begin
                mem_rd_idle <= 1'b0;
                rd_cnt      <= rd_lat;
                rd_lat_addr <= addr_rd;
            end else if (!mem_rd_idle) begin
                if (rd_cnt <= 1) mem_rd_idle <= 1'b1;
                else             rd_cnt <= rd_cnt - 1;
            end
        end
    end

    // Event monitor
    int            wr_ins_cnt = 0, rd_ins_cnt = 0, wr_ack_cnt = 0;
    int            wr_ins_cyc = 0, rd_ins_cyc = 0;
    logic [AW-1:0] wr_ins_addr = '0;

    always @(negedge clk) begin
        if (wr_ins) begin
            wr_ins_cnt  <= wr_ins_cnt + 1;
            wr_ins_cyc  <= cyc;
            wr_ins_addr <= addr_wr;
        end
        if (rd_ins) begin
            rd_ins_cnt <= rd_ins_cnt + 1;
            rd_ins_cyc <= cyc;
        end
        if (wr_ack != 2'b00) wr_ack_cnt <= wr_ack_cnt + 1;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_wr_ack(output logic [1:0] v, output int c);
        bit found = 0;
        v = 2'b00;
        c = -1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (wr_ack != 2'b00) begin
                v     = wr_ack;
                c     = cyc;
                found = 1;
            end
        end
        check_eq("wr_ack_seen", 64'(found), 64'd1);
    endtask

    task automatic wait_rd_ack(output logic [1:0] v, output logic [63:0] d, output int c);
        bit found = 0;
        v = 2'b00;
        d = '0;
        c = -1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (rd_ack != 2'b00) begin
                v     = rd_ack;
                d     = rd_data;
                c     = cyc;
                found = 1;
            end
        end
        check_eq("rd_ack_seen", 64'(found), 64'd1);
    endtask

    initial begin
        logic [1:0]  v, wv, rv;
        logic [63:0] d, rd_d;
        logic [1:0]  exp_g;
        int          c, wc, rc, n0, base, ack_base;
        bit          got_w, got_r, saw_ins;

        rst = 1'b1;
        wr_req = '0; wr_addr = '0; wr_data = '0; wr_type = '0;
        rd_req = '0; rd_addr = '0; rd_type = '0;
        wr_block = 1'b0; rd_block = 1'b0;
        wr_lat = 3; rd_lat = 2;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_wr_ins",  64'(wr_ins), 64'd0);
        check_eq("rst_rd_ins",  64'(rd_ins), 64'd0);
        check_eq("rst_wr_ack",  64'(wr_ack), 64'd0);
        check_eq("rst_rd_ack",  64'(rd_ack), 64'd0);
        check_eq("rst_rd_data", rd_data, 64'd0);
        check_eq("rst_addr_wr", 64'(addr_wr), 64'd0);
        check_eq("rst_addr_rd", 64'(addr_rd), 64'd0);
        check_eq("rst_bus_wr",  data_bus_wr, 64'd0);
        check_eq("rst_type_wr", 64'(data_type_wr), 64'd0);
        rst = 1'b0;

        // Single core-0 write, memory busy 3 cycles
        @(negedge clk);
        wr_addr[7:0]  = 8'h40;
        wr_data[63:0] = 64'h1122334455667788;
        wr_type[1:0]  = 2'b10;
        wr_req        = 2'b01;
        base          = wr_ins_cnt;
        wait_wr_ack(v, c);
        wr_req = 2'b00;
        check_eq("t1_ack",     64'(v), 64'h1);
        check_eq("t1_ins_cnt", 64'(wr_ins_cnt - base), 64'd1);
        check_eq("t1_ack_lat", 64'(c - wr_ins_cyc), 64'd5);
        check_eq("t1_addr",    64'(wr_ins_addr), 64'h40);
        check_eq("t1_data",    data_bus_wr, 64'h1122334455667788);
        check_eq("t1_type",    64'(data_type_wr), 64'd2);

        // Simultaneous reads right after reset: core 0 then core 1
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        rd_lat  = 2;
        rd_addr = {8'h20, 8'h10};
        rd_type = {2'b10, 2'b10};
        rd_req  = 2'b11;
        wait_rd_ack(v, d, c);
        rd_req = rd_req & ~v;
        check_eq("t2_first_ack",  64'(v), 64'h1);
        check_eq("t2_first_data", d, 64'h1010101010101010);
        check_eq("t2_type_rd",    64'(data_type_rd), 64'd2);
        wait_rd_ack(v, d, c);
        rd_req = rd_req & ~v;
        check_eq("t2_second_ack",  64'(v), 64'h2);
        check_eq("t2_second_data", d, 64'h2020202020202020);

        // Continuous contention over six read transactions
        @(negedge clk);
        rd_req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_rd_ack(v, d, c);
`ifdef DM_ARB_FIXED_PRIORITY_EN
            exp_g = 2'b01;
`else
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            check_eq($sformatf("t3_grant%0d", k), 64'(v), 64'(exp_g));
            check_eq($sformatf("t3_data%0d", k), d,
                     (exp_g == 2'b01) ? 64'h1010101010101010 : 64'h2020202020202020);
        end
        rd_req = 2'b00;

        // Core-1 write alongside core-0 read
        @(negedge clk);
        wr_lat = 2;
        rd_lat = 4;
        wr_addr[15:8]   = 8'h33;
        wr_data[127:64] = 64'hDEADBEEFCAFEF00D;
        wr_type[3:2]    = 2'b01;
        rd_addr[7:0]    = 8'h55;
        wr_req = 2'b10;
        rd_req = 2'b01;
        got_w = 0; got_r = 0; wv = 0; rv = 0; wc = 0; rc = 0; rd_d = '0;
        for (int i = 0; i < 100 && !(got_w && got_r); i++) begin
            @(negedge clk);
            if (!got_w && wr_ack != 2'b00) begin
                wv = wr_ack; wc = cyc; got_w = 1; wr_req = 2'b00;
            end
            if (!got_r && rd_ack != 2'b00) begin
                rv = rd_ack; rc = cyc; rd_d = rd_data; got_r = 1; rd_req = 2'b00;
            end
        end
        wr_req = 2'b00;
        rd_req = 2'b00;
        check_eq("t4_both_done", 64'(got_w && got_r), 64'd1);
        check_eq("t4_wr_ack",    64'(wv), 64'h2);
        check_eq("t4_rd_ack",    64'(rv), 64'h1);
        check_eq("t4_same_ins",  64'(wr_ins_cyc - rd_ins_cyc), 64'd0);
        check_eq("t4_wr_lat",    64'(wc - wr_ins_cyc), 64'd4);
        check_eq("t4_rd_lat",    64'(rc - rd_ins_cyc), 64'd6);
        check_eq("t4_rd_data",   rd_d, 64'h5555555555555555);
        check_eq("t4_addr_wr",   64'(addr_wr), 64'h33);
        check_eq("t4_bus_wr",    data_bus_wr, 64'hDEADBEEFCAFEF00D);
        check_eq("t4_type_wr",   64'(data_type_wr), 64'd1);

        // Reset during WAIT aborts without ack
        @(negedge clk);
        wr_lat = 8;
        wr_addr[7:0] = 8'h77;
        wr_req = 2'b01;
        ack_base = wr_ack_cnt;
        saw_ins = 0;
        for (int i = 0; i < 20 && !saw_ins; i++) begin
            @(negedge clk);
            if (wr_ins) saw_ins = 1;
        end
        check_eq("t5_ins_seen", 64'(saw_ins), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wr_req = 2'b00;
        @(negedge clk);
        check_eq("t5_wr_ins", 64'(wr_ins), 64'd0);
        check_eq("t5_wr_ack", 64'(wr_ack), 64'd0);
        check_eq("t5_rd_ins", 64'(rd_ins), 64'd0);
        check_eq("t5_rd_ack", 64'(rd_ack), 64'd0);
        check_eq("t5_addr",   64'(addr_wr), 64'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("t5_no_ack", 64'(wr_ack_cnt - ack_base), 64'd0);
        // Fresh request after abort: minimum latency from IDLE
        wr_lat = 1;
        n0 = cyc;
        wr_req = 2'b01;
        wait_wr_ack(v, c);
        wr_req = 2'b00;
        check_eq("t5_ins_next",  64'(wr_ins_cyc - n0), 64'd1);
        check_eq("t5_min_lat",   64'(c - n0), 64'd4);
        check_eq("t5_ack",       64'(v), 64'h1);

        // Memory busy at request time
        wr_block = 1'b1;
        @(negedge clk);
        base = wr_ins_cnt;
        wr_addr[7:0] = 8'h5A;
        wr_req = 2'b01;
        repeat (6) @(negedge clk);
        check_eq("t6_no_ins_now", 64'(wr_ins), 64'd0);
        check_eq("t6_no_ins_cnt", 64'(wr_ins_cnt - base), 64'd0);
        n0 = cyc;
        wr_block = 1'b0;
        wait_wr_ack(v, c);
        wr_req = 2'b00;
        check_eq("t6_ins_delay", 64'(wr_ins_cyc - n0), 64'd1);
        check_eq("t6_ins_cnt",   64'(wr_ins_cnt - base), 64'd1);
        check_eq("t6_addr",      64'(addr_wr), 64'h5A);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
